// File: rtl/switch_encoder.sv
// switch_encoder
//   Turns four raw push-button levels into a 2-bit selection code plus a
//   one-cycle VALID strobe. Each button is synchronised (two flops),
//   optionally debounced, and edge-detected. An accept FSM then registers
//   exactly one code per press. The encoding is D1=00, D2=01, D3=10, D4=11.
//   When several buttons rise together, the lowest index wins.
//
// Build option:
//   SWITCH_ENCODER_DEBOUNCE_EN  When defined, per-input debounce counters are
//                               built. When undefined, the clean level is the
//                               synchronised level, and DB_CYCLES and CNT_W
//                               have no effect.
//
// Parameters:
//   DB_CYCLES  consecutive differing synchronised samples needed before a
//              clean level changes (legal range 1..2**CNT_W)
//   CNT_W      width of each debounce counter
//
// Ports:
//   CLK    system clock, rising edge
//   RST    synchronous active-high reset
//   D1..D4 raw button levels (asynchronous to CLK, active-high)
//   SEL    code of the last accepted press
//   VALID  one-cycle pulse when SEL takes a newly accepted code
//   MULTI  one-cycle pulse with VALID when more than one clean level is high
//   HELD   OR of the four clean levels
module switch_encoder #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  output logic [1:0] SEL,
  output logic       VALID,
  output logic       MULTI,
  output logic       HELD
);

  // Elaboration-time guard on the debounce parameters.
  if (DB_CYCLES < 1 || DB_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("switch_encoder: DB_CYCLES out of range for CNT_W");
  end

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } state_t;

  logic [3:0] raw;
  logic [3:0] meta_reg;
  logic [3:0] sync_reg;
  logic [3:0] clean;
  logic [3:0] clean_d_reg;
  logic [3:0] rise;

  assign raw = {D4, D3, D2, D1};

  // Two-flop synchroniser and the delayed clean copy used for edge detect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg    <= '0;
      sync_reg    <= '0;
      clean_d_reg <= '0;
    end else begin
      meta_reg    <= raw;
      sync_reg    <= meta_reg;
      clean_d_reg <= clean;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_input
`ifdef SWITCH_ENCODER_DEBOUNCE_EN
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

      logic [CNT_W-1:0] cnt_reg;
      logic             clean_reg;

      // The counter only runs while the synchronised sample disagrees with
      // the clean level. Any agreeing sample restarts the count, so a glitch
      // shorter than DB_CYCLES samples leaves the clean level untouched.
      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
        end else if (sync_reg[gi] == clean_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          clean_reg <= sync_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign clean[gi] = clean_reg;
`else
      assign clean[gi] = sync_reg[gi];
`endif
    end
  endgenerate

  assign rise = clean & ~clean_d_reg;
  assign HELD = |clean;

  // Priority encode the rising inputs. The loop scans downward, so the
  // lowest index rising input is the one left in win_code.
  logic [1:0] win_code;
  always_comb begin
    win_code = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) win_code = 2'(i);
    end
  end

  // More than one clean level is high exactly when clearing the lowest set
  // bit still leaves a non-zero value.
  logic multi_now;
  assign multi_now = (clean & (clean - 4'd1)) != 4'd0;

  state_t     state_reg;
  logic [1:0] sel_reg;
  logic       valid_reg;
  logic       multi_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 2'd0;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|rise) begin
            sel_reg   <= win_code;
            valid_reg <= 1'b1;
            multi_reg <= multi_now;
            state_reg <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // Further rises are ignored until every button is released.
          if (clean == 4'd0) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign SEL   = sel_reg;
  assign VALID = valid_reg;
  assign MULTI = multi_reg;

endmodule

// File: tb/tb_switch_encoder.sv
module tb_switch_encoder;

  localparam int DB = 4;
`ifdef SWITCH_ENCODER_DEBOUNCE_EN
  localparam int LAT = DB + 2;   // edge index of VALID after first raw sample
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, d4 = 1'b0;
  logic [1:0] sel;
  logic       valid, multi, held;

  int checks = 0;
  int errors = 0;
  bit consec_seen = 1'b0;
  bit prev_valid  = 1'b0;

  switch_encoder #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .CLK(clk), .RST(rst), .D1(d1), .D2(d2), .D3(d3), .D4(d4),
    .SEL(sel), .VALID(valid), .MULTI(multi), .HELD(held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (valid && prev_valid) consec_seen = 1'b1;
    prev_valid = valid;
  endtask

  // Observe n edges (edge 0 is the next edge). Reports VALID count, the edge
  // of the first VALID and the SEL/MULTI seen there, the first edge with
  // HELD=1, and whether HELD was 1 at every sample.
  task automatic watch(input int n, output int nvalid, output int vedge,
                       output logic [1:0] vsel, output logic vmulti,
                       output int hedge, output bit held_all);
    nvalid = 0; vedge = -1; vsel = 2'bxx; vmulti = 1'bx; hedge = -1; held_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid) begin
        if (nvalid == 0) begin
          vedge = i; vsel = sel; vmulti = multi;
        end
        nvalid++;
      end
      if (held && hedge < 0) hedge = i;
      if (!held) held_all = 1'b0;
    end
  endtask

  task automatic release_all(input string tag);
    int n;
    d1 = 0; d2 = 0; d3 = 0; d4 = 0;
    n = 0;
    while (held && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (held !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: HELD=%b after %0d cycles, required 0", tag, held, n);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks++;
    if ({sel, valid, multi, held} !== 5'b0) begin
      errors++;
      $display("FAIL reset: SEL=%b VALID=%b MULTI=%b HELD=%b, required 00 0 0 0",
               sel, valid, multi, held);
    end
  endtask

  task automatic test_single_press();
    int nv, ve, he; logic [1:0] vs; logic vm; bit ha;
    d3 = 1;
    watch(LAT + 4, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1)   begin errors++; $display("FAIL single_count: %0d VALIDs, required 1", nv); end
    checks++; if (ve !== LAT) begin errors++; $display("FAIL single_edge: VALID at edge %0d, required %0d", ve, LAT); end
    checks++; if (he !== LAT - 1) begin errors++; $display("FAIL single_held: HELD rose at edge %0d, required %0d", he, LAT - 1); end
    checks++; if (vs !== 2'b10) begin errors++; $display("FAIL single_sel: SEL=%b, required 10", vs); end
    checks++; if (vm !== 1'b0)  begin errors++; $display("FAIL single_multi: MULTI=%b, required 0", vm); end
    release_all("single");
  endtask

  task automatic test_glitch();
    int nv, ve, he; logic [1:0] vs; logic vm; bit ha;
`ifdef SWITCH_ENCODER_DEBOUNCE_EN
    d2 = 1;
    tick(); tick(); tick();
    d2 = 0;
    watch(12, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 0)     begin errors++; $display("FAIL glitch_count: %0d VALIDs, required 0", nv); end
    checks++; if (he !== -1)    begin errors++; $display("FAIL glitch_held: HELD rose at edge %0d, required never", he); end
    checks++; if (sel !== 2'b10) begin errors++; $display("FAIL glitch_sel: SEL=%b, required 10", sel); end
`else
    d2 = 1;
    tick();
    d2 = 0;
    watch(10, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1)     begin errors++; $display("FAIL pulse_count: %0d VALIDs, required 1", nv); end
    checks++; if (vs !== 2'b01) begin errors++; $display("FAIL pulse_sel: SEL=%b, required 01", vs); end
    release_all("pulse");
`endif
  endtask

  task automatic test_simultaneous();
    int nv, ve, he; logic [1:0] vs; logic vm; bit ha;
    d2 = 1; d4 = 1;
    watch(LAT + 6, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1)     begin errors++; $display("FAIL simul_count: %0d VALIDs, required 1", nv); end
    checks++; if (ve !== LAT)   begin errors++; $display("FAIL simul_edge: VALID at edge %0d, required %0d", ve, LAT); end
    checks++; if (vs !== 2'b01) begin errors++; $display("FAIL simul_sel: SEL=%b, required 01", vs); end
    checks++; if (vm !== 1'b1)  begin errors++; $display("FAIL simul_multi: MULTI=%b, required 1", vm); end
    release_all("simul");
  endtask

  task automatic test_second_press();
    int nv, ve, he; logic [1:0] vs; logic vm; bit ha;
    d1 = 1;
    watch(LAT + 2, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1 || vs !== 2'b00) begin errors++; $display("FAIL hold_first: %0d VALIDs SEL=%b, required 1 and 00", nv, vs); end
    d4 = 1;
    watch(LAT + 6, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 0)     begin errors++; $display("FAIL hold_second_count: %0d VALIDs, required 0", nv); end
    checks++; if (ha !== 1'b1)  begin errors++; $display("FAIL hold_held: HELD dropped while held, required 1 throughout"); end
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL hold_sel: SEL=%b, required 00", sel); end
    release_all("hold");
    d4 = 1;
    watch(LAT + 4, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1 || ve !== LAT) begin errors++; $display("FAIL repress_valid: %0d VALIDs at edge %0d, required 1 at %0d", nv, ve, LAT); end
    checks++; if (vs !== 2'b11) begin errors++; $display("FAIL repress_sel: SEL=%b, required 11", vs); end
    release_all("repress");
  endtask

  task automatic test_reset_mid();
    int nv, ve, he; logic [1:0] vs; logic vm; bit ha;
    d3 = 1;
    watch(LAT + 2, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1 || vs !== 2'b10) begin errors++; $display("FAIL rstmid_accept: %0d VALIDs SEL=%b, required 1 and 10", nv, vs); end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({sel, valid, multi, held} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_state: SEL=%b VALID=%b MULTI=%b HELD=%b, required 00 0 0 0", sel, valid, multi, held);
    end
    watch(LAT + 4, nv, ve, vs, vm, he, ha);
    checks++; if (nv !== 1 || ve !== LAT) begin errors++; $display("FAIL rstmid_valid: %0d VALIDs at edge %0d, required 1 at %0d", nv, ve, LAT); end
    checks++; if (vs !== 2'b10) begin errors++; $display("FAIL rstmid_sel: SEL=%b, required 10", vs); end
    release_all("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_second_press();
    test_reset_mid();
    checks++;
    if (consec_seen) begin
      errors++;
      $display("FAIL valid_consecutive: VALID high in two consecutive cycles, required never");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
